sram_controller: RTL and testbench

//  Bridges the MEM stage's 32-bit data-memory request to an off-chip 16-bit asynchronous SRAM.

---
 rtl/sram_controller.sv | 173 +++++++++++++++++
 tb/tb_sram_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges a 32-bit data-memory request onto a 16-bit asynchronous SRAM as two half-word cycles plus wait padding.
// Optional `SRAM_ACCESS_COUNT_EN adds read_count/write_count completion counters.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] write_count
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             is_write_q, is_write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [17:0]      addr_q, addr_d;
    logic [15:0]      dq_out_q, dq_out_d;
    logic             we_n_q, we_n_d;
    logic             dq_oe_q, dq_oe_d;

    logic [31:0] offset_c;
    logic [17:0] half_base_c;
    logic        unused_offset_c;

    assign offset_c        = address - 32'(BASE_ADDR);
    assign half_base_c     = {offset_c[18:2], 1'b0};
    assign unused_offset_c = ^{offset_c[31:19], offset_c[1:0]};

    assign ready       = (state_q == S_DONE) | ((state_q == S_IDLE) & ~rd_en & ~wr_en);
    assign read_data   = rdata_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_OUT = dq_out_q;
    assign SRAM_DQ_OE  = dq_oe_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_OE_N   = 1'b0;

    // Pin registers are loaded for the state being entered so they are valid throughout LO/HI.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        we_n_d     = 1'b1;
        dq_oe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_en | wr_en) begin
                    state_d    = S_LO;
                    is_write_d = wr_en;
                    wdata_d    = write_data;
                    addr_d     = half_base_c;
                    if (wr_en) begin
                        we_n_d   = 1'b0;
                        dq_oe_d  = 1'b1;
                        dq_out_d = write_data[15:0];
                    end
                end
            end
            S_LO: begin
                state_d = S_HI;
                addr_d  = {addr_q[17:1], 1'b1};
                if (is_write_q) begin
                    we_n_d   = 1'b0;
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_q[31:16];
                end else begin
                    rdata_d[15:0] = SRAM_DQ_IN;
                end
            end
            S_HI: begin
                state_d    = S_WAIT;
                wait_cnt_d = CNT_W'(WAIT_CYCLES - 1);
                if (!is_write_q) begin
                    rdata_d[31:16] = SRAM_DQ_IN;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            we_n_q     <= we_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] read_count_q;
    logic [15:0] write_count_q;

    // Completions are counted once, in the DONE cycle; wrap is natural 16-bit overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else if (state_q == S_DONE) begin
            if (is_write_q) begin
                write_count_q <= write_count_q + 16'd1;
            end else begin
                read_count_q <= read_count_q + 16'd1;
            end
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural async SRAM model.
// Counter checks are compiled in when SRAM_ACCESS_COUNT_EN is defined.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] read_count;
    logic [15:0] write_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic        mem_init;
    logic [15:0] mem [0:63];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N)
`ifdef SRAM_ACCESS_COUNT_EN
        ,
        .read_count  (read_count),
        .write_count (write_count)
`endif
    );

    // Async SRAM: combinational read, write latched at the clock edge while WE_N is low.
    assign SRAM_DQ_IN = mem[SRAM_ADDR[5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[0] <= 16'h1234;
            mem[1] <= 16'hABCD;
            mem[4] <= 16'h4444;
            mem[5] <= 16'h5555;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[5:0]] <= SRAM_DQ_OUT;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request at the current negedge and checks every cycle through DONE (k=6).
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [17:0] exp_lo);
        logic we_cyc;
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = wd;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            we_cyc = wr && (k == 1 || k == 2);
            check($sformatf("%s ready k%0d", tag, k), 32'(ready), 32'(k == 6));
            check($sformatf("%s we_n k%0d", tag, k), 32'(SRAM_WE_N), 32'(!we_cyc));
            check($sformatf("%s oe k%0d", tag, k), 32'(SRAM_DQ_OE), 32'(we_cyc));
            if (k == 1) check($sformatf("%s addr lo", tag), 32'(SRAM_ADDR), 32'(exp_lo));
            if (k == 2) check($sformatf("%s addr hi", tag), 32'(SRAM_ADDR), 32'(exp_lo + 18'd1));
        end
    endtask

    task automatic go_idle(input int cycles);
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        mem_init   = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst read_data", read_data, 32'h0);
        check("rst addr", 32'(SRAM_ADDR), 32'h0);
        check("rst dq_out", 32'(SRAM_DQ_OUT), 32'h0);
        check("rst we_n", 32'(SRAM_WE_N), 32'h1);
        check("rst oe", 32'(SRAM_DQ_OE), 32'h0);
        rst      = 1'b0;
        mem_init = 1'b0;

        // Idle: no request, controller stays ready with bus released
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("idle ready", 32'(ready), 32'h1);
            check("idle we_n", 32'(SRAM_WE_N), 32'h1);
            check("idle oe", 32'(SRAM_DQ_OE), 32'h0);
            check("idle tie", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'h0);
        end

        // Read at base address
        @(negedge clk);
        access("rd1024", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0);
        check("rd1024 data", read_data, 32'hABCD1234);
        go_idle(2);
        check("post-read ready", 32'(ready), 32'h1);

        // Write word 1 -> half-words 2/3
        access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2);
        check("wr mem2", 32'(mem[2]), 32'h0000BEEF);
        check("wr mem3", 32'(mem[3]), 32'h0000DEAD);
        check("wr keeps rdata", read_data, 32'hABCD1234);
        go_idle(2);

        // Back-to-back reads: request held through DONE, next accepted in following IDLE
        access("b2b_a", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0);
        check("b2b_a data", read_data, 32'hABCD1234);
        @(negedge clk);
        access("b2b_b", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4);
        check("b2b_b data", read_data, 32'h55554444);
        @(negedge clk);
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b2b no reissue ready", 32'(ready), 32'h1);
            check("b2b no reissue we_n", 32'(SRAM_WE_N), 32'h1);
            @(negedge clk);
        end

        // Conflict: both enables -> write, read_data untouched
        access("conf", 1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 18'd0);
        check("conf mem0", 32'(mem[0]), 32'h0000F00D);
        check("conf mem1", 32'(mem[1]), 32'h0000CAFE);
        check("conf rdata", read_data, 32'h55554444);
        go_idle(2);

        // Abort: reset during HI of a write to word 2
        wr_en      = 1'b1;
        address    = 32'd1032;
        write_data = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        check("abort ready", 32'(ready), 32'h1);
        check("abort we_n", 32'(SRAM_WE_N), 32'h1);
        check("abort oe", 32'(SRAM_DQ_OE), 32'h0);
        check("abort rdata", read_data, 32'h0);
        check("abort lo half", 32'(mem[4]), 32'h00002222);
        rst = 1'b0;
        @(negedge clk);

        // Recovery read of conflict-written word
        access("rec", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0);
        check("rec data", read_data, 32'hCAFEF00D);
        go_idle(1);

`ifdef SRAM_ACCESS_COUNT_EN
        access("c_rd2", 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2);
        go_idle(1);
        access("c_rd3", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0);
        go_idle(1);
        access("c_wr1", 1'b0, 1'b1, 32'd1036, 32'h01020304, 18'd6);
        go_idle(1);
        access("c_wr2", 1'b0, 1'b1, 32'd1040, 32'h05060708, 18'd8);
        go_idle(1);
        check("read_count", 32'(read_count), 32'd3);
        check("write_count", 32'(write_count), 32'd2);
        dut.write_count_q = 16'hFFFF;
        @(negedge clk);
        access("c_wrap", 1'b0, 1'b1, 32'd1044, 32'h0, 18'd10);
        go_idle(1);
        check("write_count wrap", 32'(write_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
